// File: rtl/uart_transmitter.sv
// Byte-wide UART transmit stage: small FIFO feeding a start/8-data/odd-parity/stop
// serializer, with bit timing from a clock-enable divider on the system clock.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_accept,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [2:0]                    o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Handshake: a byte is taken on a rising edge where data_valid && data_accept;
  // data_accept depends only on the registered count, never on a same-cycle pop.

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic [2:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_tx;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_push    = data_valid && !w_full;
  assign w_bit_end = (r_baud == BAUD_LAST);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_pop     = (r_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign data_accept = !w_full;
  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE);
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

  // Storage carries no reset; validity is tracked entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= data_valid && w_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_head;
            r_parity <= ~^w_head;
            r_state  <= S_START;
            r_tx     <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_PARITY;
              r_tx    <= r_parity;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            // A queued byte starts its frame immediately, with no idle-high bit.
            if (w_pop) begin
              r_shift  <= w_head;
              r_parity <= ~^w_head;
              r_state  <= S_START;
              r_tx     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: scenario tasks plus a serial-line receiver model
// that pops expected bytes from a scoreboard queue as frames complete.
module tb_uart_transmitter;

  localparam int CPB   = 2;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_accept;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  uart_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_accept (data_accept),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receiver model on the serial line
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  logic       mon_par;
  logic       mon_stop;

  always @(negedge clk) begin
    logic [7:0] exp_b;
    logic       par_err;
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_byte   = '0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == 0) begin
        if (mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8) mon_byte[mon_cnt / CPB - 1] = tx;
        if (mon_cnt / CPB == 9)  mon_par  = tx;
        if (mon_cnt / CPB == 10) mon_stop = tx;
      end
      if (mon_cnt == 11 * CPB - 1) begin
        mon_active = 1'b0;
        par_err = (mon_par != ~^mon_byte);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected_frame got=%02h expected none", mon_byte);
        end else begin
          exp_b = exp_q.pop_front();
          if (mon_byte !== exp_b) begin
            errors++;
            $display("FAIL rx_byte got=%02h expected=%02h", mon_byte, exp_b);
          end
        end
        checks++;
        if (par_err !== 1'b0 || mon_stop !== 1'b1) begin
          errors++;
          $display("FAIL rx_framing parity_error=%0b stop=%0b expected 0/1", par_err, mon_stop);
        end
      end
    end
  end

  task automatic wait_idle(input int bound, input string name);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_q.size() == 0 && !mon_active) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1)          begin errors++; $display("FAIL reset_tx got=%0b expected=1", tx); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%0b expected=0", busy); end
    checks++; if (data_accept !== 1'b1) begin errors++; $display("FAIL reset_accept got=%0b expected=1", data_accept); end
    checks++; if (fifo_count !== 3'd0)  begin errors++; $display("FAIL reset_count got=%0d expected=0", fifo_count); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow got=%0b expected=0", overflow); end
    checks++; if (dbg_state !== 3'd0)   begin errors++; $display("FAIL reset_state got=%0d expected=0", dbg_state); end
  endtask

  task automatic test_single_byte();
    logic [10:0] line_bits = 11'b1_1_10100101_0;
    int busy_cycles = 0;
    int bad_bits = 0;
    data_in = 8'hA5; data_valid = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk);
    data_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_write got=%0d expected=1", fifo_count); end
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL single_tx_before_pop got=%0b expected=1", tx); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop got=%0d expected=0", fifo_count); end
    for (int off = 0; off < 11 * CPB; off++) begin
      if (off != 0) @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      if (tx !== line_bits[off / CPB]) begin
        bad_bits++;
        $display("FAIL single_tx_bit offset=%0d got=%0b expected=%0b", off, tx, line_bits[off / CPB]);
      end
    end
    checks++; if (bad_bits != 0) errors++;
    @(negedge clk);
    checks++; if (busy_cycles != 22) begin errors++; $display("FAIL single_busy_len got=%0d expected=22", busy_cycles); end
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_end busy=%0b tx=%0b expected 0/1", busy, tx); end
    wait_idle(50, "single");
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3] = '{8'h00, 8'h07, 8'hFF};
    logic       pars  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      data_in = bytes[i]; data_valid = 1'b1; exp_q.push_back(bytes[i]);
      @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
      repeat (9 * CPB) @(negedge clk);
      checks++;
      if (tx !== pars[i]) begin
        errors++;
        $display("FAIL parity_bit byte=%02h got=%0b expected=%0b", bytes[i], tx, pars[i]);
      end
      wait_idle(60, "parity");
    end
  endtask

  task automatic test_back_to_back();
    int busy_low = 0;
    data_in = 8'h11; data_valid = 1'b1; exp_q.push_back(8'h11);
    @(negedge clk);
    data_in = 8'h22; exp_q.push_back(8'h22);
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_first_start got=%0b expected=0", tx); end
    data_in = 8'h33; exp_q.push_back(8'h33);
    @(negedge clk);
    data_valid = 1'b0;
    for (int off = 1; off < 66; off++) begin
      if (off != 1) @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      if ((off == 22 || off == 44) && tx !== 1'b0) begin
        checks++; errors++;
        $display("FAIL b2b_gap offset=%0d got=%0b expected=0", off, tx);
      end else if (off == 22 || off == 44) begin
        checks++;
      end
    end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL b2b_busy_drop got=%0d expected=0", busy_low); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_total_len busy=%0b expected=0 at 66 cycles", busy); end
    wait_idle(50, "b2b");
  endtask

  task automatic test_full_overflow();
    data_in = 8'h40; data_valid = 1'b1; exp_q.push_back(8'h40);
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    data_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 8'h40 + 8'(i);
      if (i <= 4) exp_q.push_back(8'h40 + 8'(i));
      @(negedge clk);
      if (i == 3) begin
        checks++; if (data_accept !== 1'b1) begin errors++; $display("FAIL full_accept_early got=%0b expected=1", data_accept); end
      end
      if (i == 4) begin
        checks++; if (data_accept !== 1'b0) begin errors++; $display("FAIL full_accept got=%0b expected=0", data_accept); end
        checks++; if (fifo_count !== 3'd4)  begin errors++; $display("FAIL full_count got=%0d expected=4", fifo_count); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL full_overflow_early got=%0b expected=0", overflow); end
      end
    end
    data_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse got=%0b expected=1", overflow); end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%0b expected=0", overflow); end
    wait_idle(200, "full");
  endtask

  task automatic test_wrap_around();
    int sent = 0;
    for (int cyc = 0; cyc < 1000 && sent < 10; cyc++) begin
      if (data_accept === 1'b1) begin
        data_in = 8'(sent); data_valid = 1'b1; exp_q.push_back(8'(sent));
        sent++;
      end else begin
        data_valid = 1'b0;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    checks++; if (sent != 10) begin errors++; $display("FAIL wrap_sent got=%0d expected=10", sent); end
    wait_idle(400, "wrap");
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    data_in = 8'h5A; data_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h66;
    @(negedge clk);
    data_in = 8'h77;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)         begin errors++; $display("FAIL rst_mid_tx got=%0b expected=1", tx); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got=%0d expected=0", fifo_count); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got=%0b expected=0", busy); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_residual got=%0d expected=0 non-idle cycles", bad); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_full_overflow();
    test_wrap_around();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got=%0d expected=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
